// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline stage tops and the hazard controller.
// The pipeline side (master) supplies hazard inputs; the controller (slave) returns stall/flush and counters.
interface pipeline_hazard_ctrl_if #(
  parameter int NUM_MISS_SRC   = 2,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic                      trigger;
  logic [NUM_MISS_SRC-1:0]   cache_miss;
  logic [REG_ADDR_WIDTH-1:0] Rs1D;
  logic [REG_ADDR_WIDTH-1:0] Rs2D;
  logic [REG_ADDR_WIDTH-1:0] RdE;
  logic                      MemReadE;
  logic                      PCSrcE;
  logic                      StallF;
  logic                      StallD;
  logic                      StallE;
  logic                      StallM;
  logic                      StallW;
  logic                      FlushD;
  logic                      FlushE;
  logic                      hung;
  logic [CNT_WIDTH-1:0]      stall_cycles;
  logic [CNT_WIDTH-1:0]      bubble_count;
  logic [CNT_WIDTH-1:0]      flush_count;

  modport master (
    output trigger, cache_miss, Rs1D, Rs2D, RdE, MemReadE, PCSrcE,
    input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
    input  hung, stall_cycles, bubble_count, flush_count
  );

  modport slave (
    input  trigger, cache_miss, Rs1D, Rs2D, RdE, MemReadE, PCSrcE,
    output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
    output hung, stall_cycles, bubble_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: merges miss sources and run gate into a freeze,
// handles load-use bubbles and branch flushes, with post-reset hold, miss watchdog and perf counters.
module pipeline_hazard_ctrl #(
  parameter int NUM_MISS_SRC   = 2,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int INIT_CYCLES    = 4,
  parameter int TIMEOUT        = 1024,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipeline_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_HUNG
  } state_t;

  localparam int HOLD_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam int MISS_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam state_t                    RESET_STATE = (INIT_CYCLES == 0) ? ST_RUN : ST_INIT;
  localparam logic [HOLD_W-1:0]         HOLD_INIT   = HOLD_W'(INIT_CYCLES);
  localparam logic [MISS_W-1:0]         MISS_LAST   = MISS_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO    = '0;

  state_t                state_q;
  logic [HOLD_W-1:0]     hold_q;
  logic [MISS_W-1:0]     miss_cnt_q;
  logic                  hung_q;
  logic [CNT_WIDTH-1:0]  stall_cycles_q;
  logic [CNT_WIDTH-1:0]  bubble_count_q;
  logic [CNT_WIDTH-1:0]  flush_count_q;

  logic [NUM_MISS_SRC-1:0] miss_vec;
  logic any_miss;
  logic freeze;
  logic load_use;
  logic running;
  logic flush_apply;
  logic bubble_apply;
  logic stall_fd;
  logic stall_emw;
  logic flush_d;
  logic flush_e;

  assign miss_vec = hz.cache_miss;
  assign any_miss = |miss_vec;
  assign freeze   = any_miss | ~hz.trigger;
  assign load_use = hz.MemReadE && (hz.RdE != REG_ZERO) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign running  = (state_q == ST_RUN);

  // Branch and load-use are suppressed while frozen; they stay pending in E/D
  // and are applied (and counted) on the first unfrozen cycle.
  assign flush_apply  = running && !freeze && hz.PCSrcE;
  assign bubble_apply = running && !freeze && !hz.PCSrcE && load_use;

  always_comb begin
    stall_fd  = 1'b0;
    stall_emw = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    if (!running || freeze) begin
      stall_fd  = 1'b1;
      stall_emw = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_fd = 1'b1;
      flush_e  = 1'b1;
    end
  end

  assign hz.StallF       = stall_fd;
  assign hz.StallD       = stall_fd;
  assign hz.StallE       = stall_emw;
  assign hz.StallM       = stall_emw;
  assign hz.StallW       = stall_emw;
  assign hz.FlushD       = flush_d;
  assign hz.FlushE       = flush_e;
  assign hz.hung         = hung_q;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.bubble_count = bubble_count_q;
  assign hz.flush_count  = flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RESET_STATE;
      hold_q         <= HOLD_INIT;
      miss_cnt_q     <= '0;
      hung_q         <= 1'b0;
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
      flush_count_q  <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (hold_q <= HOLD_W'(1)) state_q <= ST_RUN;
          if (hold_q != '0) hold_q <= hold_q - HOLD_W'(1);
        end

        ST_RUN: begin
          if (freeze)       stall_cycles_q <= stall_cycles_q + CNT_WIDTH'(1);
          if (bubble_apply) bubble_count_q <= bubble_count_q + CNT_WIDTH'(1);
          if (flush_apply)  flush_count_q  <= flush_count_q + CNT_WIDTH'(1);

          // A run-gate-only freeze leaves the miss streak untouched.
          if (TIMEOUT != 0) begin
            if (any_miss) begin
              if (miss_cnt_q == MISS_LAST) begin
                state_q <= ST_HUNG;
                hung_q  <= 1'b1;
              end
              if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + MISS_W'(1);
            end else if (hz.trigger) begin
              miss_cnt_q <= '0;
            end
          end
        end

        ST_HUNG: begin
          hung_q <= 1'b1;
        end

        default: begin
          state_q <= RESET_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven in lockstep, checked
// every cycle against a behavioural model, plus directed literal scenarios.
module tb_pipeline_hazard_ctrl;

  localparam int P_INIT [2] = '{4, 0};
  localparam int P_TO   [2] = '{8, 0};
  localparam int P_CW   [2] = '{4, 8};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger;
  logic [1:0] cache_miss;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       MemReadE, PCSrcE;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.NUM_MISS_SRC(2), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) ifa ();
  pipeline_hazard_ctrl_if #(.NUM_MISS_SRC(2), .REG_ADDR_WIDTH(5), .CNT_WIDTH(8)) ifb ();

  assign ifa.trigger = trigger;  assign ifb.trigger = trigger;
  assign ifa.cache_miss = cache_miss;  assign ifb.cache_miss = cache_miss;
  assign ifa.Rs1D = Rs1D;  assign ifb.Rs1D = Rs1D;
  assign ifa.Rs2D = Rs2D;  assign ifb.Rs2D = Rs2D;
  assign ifa.RdE = RdE;  assign ifb.RdE = RdE;
  assign ifa.MemReadE = MemReadE;  assign ifb.MemReadE = MemReadE;
  assign ifa.PCSrcE = PCSrcE;  assign ifb.PCSrcE = PCSrcE;

  pipeline_hazard_ctrl #(
    .NUM_MISS_SRC(2), .REG_ADDR_WIDTH(5), .INIT_CYCLES(4), .TIMEOUT(8), .CNT_WIDTH(4)
  ) dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa));

  pipeline_hazard_ctrl #(
    .NUM_MISS_SRC(2), .REG_ADDR_WIDTH(5), .INIT_CYCLES(0), .TIMEOUT(0), .CNT_WIDTH(8)
  ) dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb));

  // Output vectors ordered {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE}
  logic [6:0] dut_out [2];
  logic       dut_hung[2];
  int         dut_sc[2], dut_bc[2], dut_fc[2];

  assign dut_out[0] = {ifa.StallF, ifa.StallD, ifa.StallE, ifa.StallM, ifa.StallW, ifa.FlushD, ifa.FlushE};
  assign dut_out[1] = {ifb.StallF, ifb.StallD, ifb.StallE, ifb.StallM, ifb.StallW, ifb.FlushD, ifb.FlushE};
  assign dut_hung[0] = ifa.hung;
  assign dut_hung[1] = ifb.hung;
  assign dut_sc[0] = int'(ifa.stall_cycles);
  assign dut_sc[1] = int'(ifb.stall_cycles);
  assign dut_bc[0] = int'(ifa.bubble_count);
  assign dut_bc[1] = int'(ifb.bubble_count);
  assign dut_fc[0] = int'(ifa.flush_count);
  assign dut_fc[1] = int'(ifb.flush_count);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining hold cycles, hang flag, consecutive-miss streak, counters.
  int m_hold[2], m_streak[2], m_sc[2], m_bc[2], m_fc[2];
  bit m_hung[2];

  function automatic bit hazard_lu();
    return MemReadE && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  function automatic logic [6:0] exp_out(input int i);
    bit frz;
    frz = (cache_miss != 2'b00) || !trigger;
    if (m_hold[i] > 0 || m_hung[i]) return 7'b1111100;
    if (frz)         return 7'b1111100;
    if (PCSrcE)      return 7'b0000011;
    if (hazard_lu()) return 7'b1100001;
    return 7'b0000000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_hold[i] = P_INIT[i];
        m_hung[i] = 1'b0;
        m_streak[i] = 0;
        m_sc[i] = 0;
        m_bc[i] = 0;
        m_fc[i] = 0;
      end else if (m_hold[i] > 0) begin
        m_hold[i]--;
      end else if (!m_hung[i]) begin
        if ((cache_miss != 2'b00) || !trigger) m_sc[i] = (m_sc[i] + 1) % (1 << P_CW[i]);
        else if (PCSrcE)                       m_fc[i] = (m_fc[i] + 1) % (1 << P_CW[i]);
        else if (hazard_lu())                  m_bc[i] = (m_bc[i] + 1) % (1 << P_CW[i]);
        if (P_TO[i] != 0) begin
          if (cache_miss != 2'b00) begin
            m_streak[i]++;
            if (m_streak[i] >= P_TO[i]) m_hung[i] = 1'b1;
          end else if (trigger) begin
            m_streak[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("outs_dut%0d", i), 64'(dut_out[i]), 64'(exp_out(i)));
        chk($sformatf("hung_dut%0d", i), 64'(dut_hung[i]), 64'(m_hung[i]));
        chk($sformatf("stall_cycles_dut%0d", i), 64'(dut_sc[i]), 64'(m_sc[i]));
        chk($sformatf("bubble_count_dut%0d", i), 64'(dut_bc[i]), 64'(m_bc[i]));
        chk($sformatf("flush_count_dut%0d", i), 64'(dut_fc[i]), 64'(m_fc[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int burst;

  initial begin
    rst_n = 1'b0;
    trigger = 1'b1;
    cache_miss = 2'b00;
    Rs1D = '0; Rs2D = '0; RdE = '0;
    MemReadE = 1'b0; PCSrcE = 1'b0;
    burst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall_a", 64'(dut_out[0]), 64'(7'b1111100));
    chk("rst_stall_b", 64'(dut_out[1]), 64'(7'b0000000));
    chk("rst_hung_a", 64'(ifa.hung), 64'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Post-reset hold: four edges of full stall on the INIT_CYCLES=4 instance.
    chk("init_hold_0", 64'({ifa.StallF, ifa.StallW}), 64'(2'b11));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("init_hold_%0d", k), 64'({ifa.StallF, ifa.StallW}), (k < 4) ? 64'(2'b11) : 64'(2'b00));
    end
    chk("init_counters", 64'({ifa.stall_cycles, ifa.bubble_count, ifa.flush_count}), 64'(0));

    // Load-use: one bubble, then the load has moved on.
    MemReadE = 1'b1; RdE = 5'd5; Rs2D = 5'd5; Rs1D = 5'd3;
    #1 chk("lu_outs", 64'(dut_out[0]), 64'(7'b1100001));
    tick();
    MemReadE = 1'b0; RdE = 5'd0;
    #1 chk("lu_once", 64'(dut_out[0]), 64'(0));
    chk("lu_bubble", 64'(ifa.bubble_count), 64'(1));
    MemReadE = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
    #1 chk("lu_x0", 64'(dut_out[0]), 64'(0));
    tick();
    MemReadE = 1'b0;
    #1 chk("lu_x0_bubble", 64'(ifa.bubble_count), 64'(1));

    // Branch held behind a 3-cycle miss, applied on the first unfrozen cycle.
    PCSrcE = 1'b1; cache_miss = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("br_frozen_%0d", k), 64'(dut_out[0]), 64'(7'b1111100));
      tick();
    end
    cache_miss = 2'b00;
    #1 chk("br_flush", 64'(dut_out[0]), 64'(7'b0000011));
    tick();
    PCSrcE = 1'b0;
    #1 chk("br_stall_cycles", 64'(ifa.stall_cycles), 64'(3));
    chk("br_flush_count", 64'(ifa.flush_count), 64'(1));

    // Run gate low for 5 cycles.
    trigger = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("trig_frozen_%0d", k), 64'(dut_out[0]), 64'(7'b1111100));
      tick();
    end
    trigger = 1'b1;
    #1 chk("trig_stall_cycles", 64'(ifa.stall_cycles), 64'(8));
    chk("trig_hung", 64'(ifa.hung), 64'(0));

    // Watchdog: 7 + gap + 7 misses must not trip.
    cache_miss = 2'b01;
    repeat (7) tick();
    cache_miss = 2'b00;
    tick();
    cache_miss = 2'b01;
    repeat (7) tick();
    cache_miss = 2'b00;
    #1 chk("wd_no_hang", 64'(ifa.hung), 64'(0));
    chk("wd_sc_wrap", 64'(ifa.stall_cycles), 64'(6));
    tick();
    cache_miss = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("wd_trip_%0d", k), 64'(ifa.hung), (k == 8) ? 64'(1) : 64'(0));
    end
    chk("wd_sc_final", 64'(ifa.stall_cycles), 64'(14));
    cache_miss = 2'b00;
    tick();
    chk("wd_sticky", 64'(ifa.hung), 64'(1));
    chk("wd_hung_outs", 64'(dut_out[0]), 64'(7'b1111100));
    chk("nowd_hung_b", 64'(ifb.hung), 64'(0));
    chk("nowd_sc_b", 64'(ifb.stall_cycles), 64'(30));

    // Asynchronous reset in HUNG.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_hung_clear", 64'(ifa.hung), 64'(0));
    chk("rst_hung_init", 64'(dut_out[0]), 64'(7'b1111100));
    chk("rst_hung_cnt", 64'(ifa.stall_cycles), 64'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic with occasional miss bursts and async resets.
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      if (burst == 0 && $urandom_range(0, 59) == 0) burst = int'($urandom_range(5, 10));
      if (burst > 0) begin
        cache_miss = 2'($urandom_range(1, 3));
        burst--;
      end else begin
        cache_miss = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      end
      trigger  = ($urandom_range(0, 9) != 0);
      MemReadE = ($urandom_range(0, 2) == 0);
      PCSrcE   = ($urandom_range(0, 5) == 0);
      RdE      = 5'($urandom_range(0, 3));
      Rs1D     = 5'($urandom_range(0, 3));
      Rs2D     = 5'($urandom_range(0, 3));
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
